// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit for the execute stage. It holds the
//   architectural HI/LO registers and serves mfhi/mflo reads.
//   mult/multu use a shift-add loop and div/divu use a restoring
//   shift-subtract loop. Each loop takes DATA_W cycles, followed by one
//   sign-fix cycle.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, operation   HiLo_Ctrl strobe and op code (011000 mult,
//                      011001 multu, 011010 div, 011011 divu)
//   operand_a/b        rs / rt values
//   mfhi, mflo         HI / LO read requests
//   flush              abort an in-flight operation
//   busy, done, stall  status (done = one-cycle pulse, new HI/LO visible)
//   hi, lo             architectural HI / LO registers
//   read_data          mfhi/mflo result (HI has priority)
//   dbg_state          current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// Handshake: an operation is accepted on a rising edge where the unit is
// IDLE, start=1, the op code is valid and flush=0. While busy, start and
// mfhi/mflo raise stall and are not acted on. Upstream holds the
// instruction until stall drops.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        operation,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              mfhi,
  input  logic              mflo,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] read_data,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_acc;     // mult: {partial, multiplier}; div: {rem, quot}
  logic [DATA_W-1:0]     r_b;       // multiplicand / divisor magnitude
  logic [DATA_W-1:0]     r_raw_a;
  logic                  r_is_div;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dbz;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_done;

  logic                  w_op_valid;
  logic                  w_op_signed;
  logic                  w_op_div;
  logic                  w_accept;
  logic [DATA_W-1:0]     w_a_mag;
  logic [DATA_W-1:0]     w_b_mag;
  logic [DATA_W:0]       w_mul_sum;
  logic [2*DATA_W-1:0]   w_mul_next;
  logic [DATA_W:0]       w_rem_sh;
  logic [DATA_W:0]       w_diff;
  logic [2*DATA_W-1:0]   w_div_next;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quot;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_fix_hi;
  logic [DATA_W-1:0]     w_fix_lo;
  logic                  w_commit;

  assign w_op_valid  = (operation == OP_MULT) || (operation == OP_MULTU) ||
                       (operation == OP_DIV)  || (operation == OP_DIVU);
  assign w_op_signed = (operation == OP_MULT) || (operation == OP_DIV);
  assign w_op_div    = (operation == OP_DIV)  || (operation == OP_DIVU);
  assign w_accept    = (r_state == S_IDLE) && start && w_op_valid && !flush;

  assign w_a_mag = (w_op_signed && operand_a[DATA_W-1]) ? -operand_a : operand_a;
  assign w_b_mag = (w_op_signed && operand_b[DATA_W-1]) ? -operand_b : operand_b;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_W-1:1]}
                               : {1'b0, r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1:1]};

  // Restoring step: shift the next dividend bit into the remainder and try
  // a subtract. A non-negative result is kept and yields quotient bit 1.
  assign w_rem_sh   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[DATA_W] ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                                     : {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

  // Sign fix. The most-negative / -1 case falls out naturally: the quotient
  // magnitude 2^(W-1) negates to itself mod 2^W, and the remainder is 0.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
    w_fix_lo = w_prod[DATA_W-1:0];
    if (r_is_div) begin
      if (r_dbz) begin
        w_fix_hi = r_raw_a;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quot;
      end
    end
  end

  assign w_commit = (r_state == S_FIX) && !flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (flush)                   w_next = S_IDLE;
        else if (r_cnt == LAST_ITER) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_commit;
      if (w_commit) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_raw_a  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= {{DATA_W{1'b0}}, w_a_mag};
      r_b      <= w_b_mag;
      r_raw_a  <= operand_a;
      r_is_div <= w_op_div;
      r_neg_q  <= w_op_signed && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
      r_neg_r  <= (operation == OP_DIV) && operand_a[DATA_W-1];
      r_dbz    <= w_op_div && (operand_b == '0);
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign stall     = busy & (mfhi | mflo | start);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign read_data = mfhi ? r_hi : (mflo ? r_lo : '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_BAD   = 6'b100000;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [5:0]   operation;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         mfhi;
  logic         mflo;
  logic         flush;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] read_data;
  logic [1:0]   dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  hilo_muldiv_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .operand_a(operand_a), .operand_b(operand_b), .mfhi(mfhi), .mflo(mflo),
    .flush(flush), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo),
    .read_data(read_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse pops one expected {hi,lo}
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("hilo_result", {hi, lo}, e);
      end
    end
  end

  // driver: issue one op, wait for completion, check timing around done
  task automatic run_op(input string name, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input bit use_mflo);
    int cnt;
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    start = 1'b1; operation = op; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    if (use_mflo) begin
      mflo = 1'b1;
      #1;
      check({name, "_stall_mflo"}, 64'(stall), 64'd1);
    end
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'd33);
    check({name, "_done"}, 64'(done), 64'd1);
    if (use_mflo) begin
      check({name, "_rd_lo"}, 64'(read_data), 64'(elo));
      check({name, "_stall_done"}, 64'(stall), 64'd0);
      mflo = 1'b0;
    end
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0; start = 1'b0; operation = '0; operand_a = '0; operand_b = '0;
    mfhi = 1'b0; mflo = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {busy, done, stall}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b1);
    mfhi = 1'b1; mflo = 1'b1;
    #1;
    check("rd_hi_priority", 64'(read_data), 64'd2);
    mfhi = 1'b0;
    #1;
    check("rd_lo_only", 64'(read_data), 64'd14);
    mflo = 1'b0;
    #1;
    check("rd_none", 64'(read_data), 64'd0);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_zero", OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b0);
    run_op("div_zero",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

    // flush mid-CALC, with a start held while busy
    @(negedge clk);
    start = 1'b1; operation = OP_MULTU; operand_a = 32'd5; operand_b = 32'd6;
    @(negedge clk);                       // CALC cycle 1
    operation = OP_DIVU;                  // held start while busy
    #1;
    check("held_start_stall", {busy, stall}, 64'd3);
    repeat (3) @(negedge clk);            // CALC cycle 4
    check("held_start_still_stall", {busy, stall}, 64'd3);
    start = 1'b0;
    repeat (6) @(negedge clk);            // CALC cycle 10
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(n_done), 64'd0);
    check("flush_no_restart", 64'(busy), 64'd0);
    check("flush_hilo_kept", {hi, lo}, {32'hFFFFFFF9, 32'hFFFFFFFF});

    // asynchronous reset mid-CALC
    start = 1'b1; operation = OP_MULTU; operand_a = 32'd3; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_status", {busy, done, stall, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 64'(done), 64'd0);

    // invalid op code is ignored
    start = 1'b1; operation = OP_BAD; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("bad_op_idle", {busy, dbg_state}, 64'd0);
    repeat (3) @(negedge clk);
    check("bad_op_stays_idle", {busy, done}, 64'd0);

    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
